// File: rtl/clkgen_ctrl.sv
// Programmable clock-waveform controller: period/high/phase counted in clk cycles,
// glitch-free reconfiguration at period boundaries. Optional burst mode: CLKGEN_BURST_EN.
module clkgen_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    // cfg handshake: a transfer happens on a posedge where cfg_valid && cfg_ready;
    // cfg_period/high/phase must be stable while cfg_valid is high.
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [CNT_W-1:0] cfg_period,
    input  logic [CNT_W-1:0] cfg_high,
    input  logic [CNT_W-1:0] cfg_phase,
`ifdef CLKGEN_BURST_EN
    input  logic [CNT_W-1:0] cfg_count,
    output logic             done,
`endif
    input  logic             start,
    input  logic             stop,
    output logic             clk_out,
    output logic             rise_pulse,
    output logic             running,
    output logic             cfg_err,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PHASE = 2'd1,
        S_HIGH  = 2'd2,
        S_LOW   = 2'd3
    } state_e;

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] act_period_q, act_period_d;
    logic [CNT_W-1:0] act_high_q, act_high_d;
    logic [CNT_W-1:0] act_phase_q, act_phase_d;
    logic [CNT_W-1:0] sh_period_q, sh_period_d;
    logic [CNT_W-1:0] sh_high_q, sh_high_d;
    logic [CNT_W-1:0] sh_phase_q, sh_phase_d;
    logic             pending_q, pending_d;
    logic             stop_req_q, stop_req_d;
    logic             clk_out_q, clk_out_d;
    logic             rise_q, rise_d;
    logic             running_q, running_d;
    logic             cfg_err_q, cfg_err_d;
    logic             cfg_fire, cfg_legal, cnt_zero, burst_end;

`ifdef CLKGEN_BURST_EN
    logic [CNT_W-1:0] act_count_q, act_count_d;
    logic [CNT_W-1:0] sh_count_q, sh_count_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic             done_q, done_d;

    // rem_q counts high pulses still owed after the current one.
    assign burst_end = (act_count_q != '0) && (rem_q == '0);
`else
    assign burst_end = 1'b0;
`endif

    assign cfg_ready = !pending_q;
    assign cfg_fire  = cfg_valid && cfg_ready;
    assign cfg_legal = (cfg_period >= TWO) && (cfg_high != '0) && (cfg_high < cfg_period);
    assign cnt_zero  = (cnt_q == '0);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        act_period_d = act_period_q;
        act_high_d   = act_high_q;
        act_phase_d  = act_phase_q;
        sh_period_d  = sh_period_q;
        sh_high_d    = sh_high_q;
        sh_phase_d   = sh_phase_q;
        pending_d    = pending_q;
        stop_req_d   = stop_req_q;
        cfg_err_d    = cfg_fire && !cfg_legal;
`ifdef CLKGEN_BURST_EN
        act_count_d  = act_count_q;
        sh_count_d   = sh_count_q;
        rem_d        = rem_q;
`endif

        case (state_q)
            S_IDLE: begin
                stop_req_d = 1'b0;
                if (cfg_fire && cfg_legal) begin
                    act_period_d = cfg_period;
                    act_high_d   = cfg_high;
                    act_phase_d  = cfg_phase;
`ifdef CLKGEN_BURST_EN
                    act_count_d  = cfg_count;
`endif
                end
                if (start && !stop) begin
`ifdef CLKGEN_BURST_EN
                    rem_d = act_count_q;
`endif
                    if (act_phase_q != '0) begin
                        state_d = S_PHASE;
                        cnt_d   = act_phase_q - ONE;
                    end else begin
                        state_d = S_HIGH;
                        cnt_d   = act_high_q - ONE;
`ifdef CLKGEN_BURST_EN
                        if (act_count_q != '0) rem_d = act_count_q - ONE;
`endif
                    end
                end
            end
            S_PHASE: begin
                if (cnt_zero) begin
                    state_d = S_HIGH;
                    cnt_d   = act_high_q - ONE;
`ifdef CLKGEN_BURST_EN
                    if (rem_q != '0) rem_d = rem_q - ONE;
`endif
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_HIGH: begin
                if (cnt_zero) begin
                    state_d = S_LOW;
                    cnt_d   = act_period_q - act_high_q - ONE;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_LOW: begin
                if (cnt_zero) begin
                    // Period boundary: the only point where timing may change.
                    if (stop_req_q || stop || burst_end) begin
                        state_d    = S_IDLE;
                        stop_req_d = 1'b0;
                    end else begin
                        state_d = S_HIGH;
                        cnt_d   = pending_q ? (sh_high_q - ONE) : (act_high_q - ONE);
`ifdef CLKGEN_BURST_EN
                        if (rem_q != '0) rem_d = rem_q - ONE;
`endif
                    end
                    if (pending_q) begin
                        act_period_d = sh_period_q;
                        act_high_d   = sh_high_q;
                        act_phase_d  = sh_phase_q;
`ifdef CLKGEN_BURST_EN
                        act_count_d  = sh_count_q;
`endif
                        pending_d    = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // cfg_fire implies !pending_q, so this never collides with a boundary load.
        if (state_q != S_IDLE) begin
            if (cfg_fire && cfg_legal) begin
                sh_period_d = cfg_period;
                sh_high_d   = cfg_high;
                sh_phase_d  = cfg_phase;
`ifdef CLKGEN_BURST_EN
                sh_count_d  = cfg_count;
`endif
                pending_d   = 1'b1;
            end
            if (stop && state_d != S_IDLE) stop_req_d = 1'b1;
        end

        clk_out_d = (state_d == S_HIGH);
        rise_d    = (state_d == S_HIGH) && (state_q != S_HIGH);
        running_d = (state_d != S_IDLE);
`ifdef CLKGEN_BURST_EN
        done_d    = (state_q != S_IDLE) && (state_d == S_IDLE);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            act_period_q <= TWO;
            act_high_q   <= ONE;
            act_phase_q  <= '0;
            sh_period_q  <= TWO;
            sh_high_q    <= ONE;
            sh_phase_q   <= '0;
            pending_q    <= 1'b0;
            stop_req_q   <= 1'b0;
            clk_out_q    <= 1'b0;
            rise_q       <= 1'b0;
            running_q    <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            act_period_q <= act_period_d;
            act_high_q   <= act_high_d;
            act_phase_q  <= act_phase_d;
            sh_period_q  <= sh_period_d;
            sh_high_q    <= sh_high_d;
            sh_phase_q   <= sh_phase_d;
            pending_q    <= pending_d;
            stop_req_q   <= stop_req_d;
            clk_out_q    <= clk_out_d;
            rise_q       <= rise_d;
            running_q    <= running_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

`ifdef CLKGEN_BURST_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_count_q <= '0;
            sh_count_q  <= '0;
            rem_q       <= '0;
            done_q      <= 1'b0;
        end else begin
            act_count_q <= act_count_d;
            sh_count_q  <= sh_count_d;
            rem_q       <= rem_d;
            done_q      <= done_d;
        end
    end

    assign done = done_q;
`endif

    assign clk_out    = clk_out_q;
    assign rise_pulse = rise_q;
    assign running    = running_q;
    assign cfg_err    = cfg_err_q;
    assign dbg_state  = state_q;

endmodule

// File: doc/clkgen_ctrl.md
Name: clkgen_ctrl

Overview:
- Synthesizable programmable clock-waveform controller.
- Derives a gated output waveform (`clk_out`) from the single system clock using three cycle-count parameters: period, high time and start phase.
- Sequences start/stop and accepts reconfiguration through a valid/ready handshake. New settings apply only at period boundaries, so the output never glitches.
- Sits between the testbench/CSR config source and any block that needs a derived strobe or slow clock-enable.

Parameters:
- CNT_W, 16, width of the period/high/phase counters and config fields.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  config request.
- cfg_ready  out  1  controller can accept a config this cycle.
- cfg_period  in  CNT_W  period in clk cycles.
- cfg_high  in  CNT_W  high time in clk cycles.
- cfg_phase  in  CNT_W  clk cycles of low before the first high after start.
- start  in  1  single-cycle start request.
- stop  in  1  single-cycle stop request (graceful).
- clk_out  out  1  generated waveform, registered.
- rise_pulse  out  1  1-cycle pulse in the first cycle clk_out is high.
- running  out  1  high in states PHASE/HIGH/LOW.
- cfg_err  out  1  1-cycle pulse when an accepted config is illegal.

Behaviour:
- Reset (rst_n=0, async): state=IDLE, clk_out=0, rise_pulse=0, running=0, cfg_err=0, cfg_ready=1, pending=0.
  - Active config resets to period=2, high=1, phase=0.
- Config legality: period>=2, 1<=high<=period-1. Illegal config completes the handshake, pulses cfg_err the next cycle, and changes nothing.
- States: IDLE, PHASE, HIGH, LOW. clk_out=1 exactly while state==HIGH (registered next-state decode, so no combinational path to the output).
- IDLE:
  - cfg handshake writes the active config directly.
  - start=1 and stop=0 -> PHASE if phase>0, else HIGH.
  - start and stop together -> stay IDLE.
- PHASE: hold for phase cycles -> HIGH.
- HIGH: hold for high cycles -> LOW.
- LOW: hold for period-high cycles. At its last cycle:
  - stop_req set -> IDLE.
  - else if pending set -> load shadow into active, clear pending, -> HIGH with the new timing.
  - else -> HIGH.
  - Phase is applied only on start, never on reload.
- Latency: start sampled at posedge N with phase=0 gives clk_out=1 in cycle N+1. With phase=P, clk_out=1 in cycle N+1+P.
- Config while running:
  - Legal config goes to a shadow register and sets pending.
  - cfg_ready=0 while pending=1 (one outstanding update).
  - cfg_ready returns to 1 in the cycle after the shadow load.
  - A config accepted in the same cycle as the boundary load waits for the next boundary.
- Stop:
  - A stop seen in any running state sets stop_req.
  - The current period completes (PHASE proceeds through HIGH and LOW).
  - Then IDLE with clk_out=0. stop_req clears on entering IDLE.
  - stop in IDLE is ignored. start while running is ignored.
- Counter: a single down-counter, loaded on each state entry with (duration-1). The state advances when it reads 0. There is no wrap-around: all durations are bounded by CNT_W and checked for legality.
- Reset mid-operation: immediate return to reset values. A pending config is discarded.

Optional Feature:
- Macro: CLKGEN_BURST_EN.
- With the macro defined:
  - Adds inputs cfg_count[CNT_W] (captured with config) and output done (1-cycle pulse).
  - cfg_count=0 means free-run.
  - For N>0, exactly N high pulses are generated after start, then the block returns to IDLE, pulsing done on the IDLE-entry cycle.
  - A stop still ends the burst early at the period boundary, and done still pulses.
- Without the macro: the ports are absent and the block is always free-running.

Test Plan:
- Config period=10, high=2, phase=0; start at cycle 5 -> clk_out high in cycles 6-7, low 8-15, high again 16-17; rise_pulse at 6 and 16; running=1 from 6.
- Config period=4, high=2, phase=3; start at cycle 0 -> clk_out low in cycles 1-3, first high at 4-5, then a repeating period of 4.
- Running period=10/high=5; new config period=6/high=3 sent mid-HIGH -> cfg_ready=0 until the boundary; the next period shows 3 high / 3 low; no short or merged pulse.
- Config high=0, then config period=4/high=4 -> handshake completes; cfg_err pulses each time; the waveform is unchanged.
- stop asserted in the 1st HIGH cycle of period=8/high=3 -> remaining 2 high + 5 low cycles complete, then IDLE, clk_out=0, running=0; start and stop together in IDLE -> no activity.
- rst_n pulled low mid-HIGH with a config pending -> clk_out=0 immediately; after release a start uses period=2/high=1. With CLKGEN_BURST_EN, count=3 -> exactly 3 rises, then done pulses once.
